// File: rtl/updown_bus_pkg.sv
// Shared constants for the up/down counter register-bus master.
// Holds register addresses, one-hot FSM encodings and default phase timing.
package updown_bus_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TMR_W   = 8;
  localparam int unsigned STATE_W = 5;

  // Counter peripheral register map
  localparam logic [1:0] ADDR_PLR = 2'b00;
  localparam logic [1:0] ADDR_ULR = 2'b01;
  localparam logic [1:0] ADDR_LLR = 2'b10;
  localparam logic [1:0] ADDR_CCR = 2'b11;

  // One-hot state encodings
  localparam logic [STATE_W-1:0] S_IDLE   = 5'b00001;
  localparam logic [STATE_W-1:0] S_SETUP  = 5'b00010;
  localparam logic [STATE_W-1:0] S_STROBE = 5'b00100;
  localparam logic [STATE_W-1:0] S_HOLD   = 5'b01000;
  localparam logic [STATE_W-1:0] S_START  = 5'b10000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETUP  = S_SETUP,
    ST_STROBE = S_STROBE,
    ST_HOLD   = S_HOLD,
    ST_START  = S_START
  } state_t;

  // Default phase lengths in clock cycles
  localparam int unsigned DEF_SETUP_CYC  = 1;
  localparam int unsigned DEF_STROBE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC   = 1;
  localparam int unsigned DEF_START_CYC  = 1;

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter that times each bus phase.
// Ports: clk_in/reset_in clock and async active-low reset; load/load_val
// reload the count; expired is high while the count is zero.
module bus_phase_timer
  import updown_bus_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] r_count;

  // Count down to zero and park there until the next load
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/updown_cfg_master.sv
// Register-bus initiator for the up/down counter peripheral.
// Turns single-cycle commands into timed ncs/nrd/nwr bus cycles, issues the
// start pulse and keeps sticky ec/err status.
// Ports: cmd_* command handshake, rsp_* read response, start_req start
// request, ncs/nrd/nwr/A0/A1/bus_* peripheral bus, start_out counter start,
// ec_in/err_in counter flags, status_* latched flags.
module updown_cfg_master
  import updown_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned START_CYC  = DEF_START_CYC
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              start_req,
  output logic              ncs,
  output logic              nrd,
  output logic              nwr,
  output logic              A0,
  output logic              A1,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_din,
  output logic              start_out,
  input  logic              ec_in,
  input  logic              err_in,
  output logic              status_ec,
  output logic              status_err
);

  state_t              r_state,     w_state_nxt;
  logic                r_cmd_ready;
  logic                r_ncs,       w_ncs;
  logic                r_nrd,       w_nrd;
  logic                r_nwr,       w_nwr;
  logic                r_a0,        w_a0;
  logic                r_a1,        w_a1;
  logic [DATA_W-1:0]   r_dout,      w_dout;
  logic                r_oe,        w_oe;
  logic                r_start,     w_start;
  logic                r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0]   r_rdata,     w_rdata;
  logic                r_wr,        w_wr;
  logic                r_ec,        w_ec;
  logic                r_err,       w_err;
  logic                w_clr;
  logic                w_load;
  logic [TMR_W-1:0]    w_load_val;
  logic                w_expired;

  bus_phase_timer u_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ncs       = r_ncs;
    w_nrd       = r_nrd;
    w_nwr       = r_nwr;
    w_a0        = r_a0;
    w_a1        = r_a1;
    w_dout      = r_dout;
    w_oe        = r_oe;
    w_start     = r_start;
    w_rsp_valid = 1'b0;
    w_rdata     = r_rdata;
    w_wr        = r_wr;
    w_clr       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_SETUP;
          w_ncs       = 1'b0;
          w_a0        = cmd_addr[1];
          w_a1        = cmd_addr[0];
          w_dout      = cmd_wdata;
          w_oe        = cmd_write;
          w_wr        = cmd_write;
        end else if (start_req) begin
          w_state_nxt = ST_START;
          w_start     = 1'b1;
          w_clr       = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_expired) begin
          w_state_nxt = ST_STROBE;
          if (r_wr) w_nwr = 1'b0;
          else      w_nrd = 1'b0;
        end
      end
      ST_STROBE: begin
        if (w_expired) begin
          w_state_nxt = ST_HOLD;
          w_nwr       = 1'b1;
          w_nrd       = 1'b1;
          // Sample at the edge that ends the strobe, while nrd is still low
          if (!r_wr) w_rdata = bus_din;
        end
      end
      ST_HOLD: begin
        if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_ncs       = 1'b1;
          w_oe        = 1'b0;
          w_rsp_valid = !r_wr;
        end
      end
      ST_START: begin
        if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_start     = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ncs       = 1'b1;
        w_nrd       = 1'b1;
        w_nwr       = 1'b1;
        w_oe        = 1'b0;
        w_start     = 1'b0;
      end
    endcase

    // Sticky status; a start clear overrides same-cycle flags
    w_ec  = w_clr ? 1'b0 : (r_ec  | ec_in);
    w_err = w_clr ? 1'b0 : (r_err | err_in);
  end

  // Reload the phase timer on entry to every timed state
  always_comb begin
    w_load     = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);
    w_load_val = '0;
    case (w_state_nxt)
      ST_SETUP:  w_load_val = TMR_W'(SETUP_CYC - 1);
      ST_STROBE: w_load_val = TMR_W'(STROBE_CYC - 1);
      ST_HOLD:   w_load_val = TMR_W'(HOLD_CYC - 1);
      ST_START:  w_load_val = TMR_W'(START_CYC - 1);
      default:   w_load_val = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_ncs       <= 1'b1;
      r_nrd       <= 1'b1;
      r_nwr       <= 1'b1;
      r_a0        <= 1'b0;
      r_a1        <= 1'b0;
      r_dout      <= '0;
      r_oe        <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_wr        <= 1'b0;
      r_ec        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_ncs       <= w_ncs;
      r_nrd       <= w_nrd;
      r_nwr       <= w_nwr;
      r_a0        <= w_a0;
      r_a1        <= w_a1;
      r_dout      <= w_dout;
      r_oe        <= w_oe;
      r_start     <= w_start;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
      r_wr        <= w_wr;
      r_ec        <= w_ec;
      r_err       <= w_err;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign ncs        = r_ncs;
  assign nrd        = r_nrd;
  assign nwr        = r_nwr;
  assign A0         = r_a0;
  assign A1         = r_a1;
  assign bus_dout   = r_dout;
  assign bus_oe     = r_oe;
  assign start_out  = r_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign status_ec  = r_ec;
  assign status_err = r_err;

endmodule

// File: doc/updown_cfg_master.md
Name: updown_cfg_master

Overview:
- Bus initiator that programs and starts the up/down counter peripheral over its chip-select/strobe register interface (ncs, nrd, nwr, A0, A1, 8-bit data, start_in).
- Converts single-cycle command requests from the local controller into timed register-write and register-read bus cycles, generates the start pulse, and latches ec/err status from the counter.

Parameters:
- SETUP_CYC, 1, cycles ncs/address/data are valid before the strobe falls (1..255)
- STROBE_CYC, 2, cycles nrd/nwr are held low (1..255)
- HOLD_CYC, 1, cycles ncs/address/data are held after the strobe rises (1..255)
- START_CYC, 1, cycles start_out is held high (1..255)

Ports:
- clk_in  in  1  clock; all logic on the rising edge
- reset_in  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high while in IDLE; a command is accepted on cmd_valid&&cmd_ready
- cmd_write  in  1  1 = register write, 0 = register read
- cmd_addr  in  2  register select: 00 PLR, 01 ULR, 10 LLR, 11 CCR
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_rdata  out  8  read data, held until the next read
- start_req  in  1  request a start pulse
- ncs, nrd, nwr  out  1 each  active-low chip select, read strobe and write strobe
- A0, A1  out  1 each  address lines: A0 = cmd_addr[1], A1 = cmd_addr[0]
- bus_dout  out  8  data driven toward the peripheral
- bus_oe  out  1  data bus output enable; the top-level tristate drives bus_dout when high
- bus_din  in  8  data bus sampled on reads
- start_out  out  1  drives the counter's start_in
- ec_in, err_in  in  1 each  counter end-count and error outputs
- status_ec, status_err  out  1 each  sticky latched copies of ec_in and err_in

Behaviour:
- All bus outputs are registered.
- Reset values: ncs=1, nrd=1, nwr=1, A0=0, A1=0, bus_oe=0, bus_dout=0, start_out=0, rsp_valid=0, rsp_rdata=0, status_ec=0, status_err=0. State is IDLE, so cmd_ready=1.
- States (one-hot): IDLE, SETUP, STROBE, HOLD, START.
- IDLE:
  - cmd_valid has priority over start_req.
  - On a command accept, A0/A1 and bus_dout load from the command and the state moves to SETUP. From the next cycle ncs=0, and bus_oe=1 for writes only.
  - Otherwise, if start_req=1, the state moves to START.
- SETUP: lasts SETUP_CYC cycles, then moves to STROBE.
- STROBE:
  - Lasts STROBE_CYC cycles with nwr=0 (write) or nrd=0 (read).
  - On reads, rsp_rdata captures bus_din at the clock edge that ends the last STROBE cycle.
  - Then moves to HOLD.
- HOLD: strobes are high; ncs, address and data stay stable for HOLD_CYC cycles. Then the state returns to IDLE with ncs=1 and bus_oe=0.
- Read response: rsp_valid=1 for exactly the first IDLE cycle after a read. Write commands never assert rsp_valid.
- Write bus occupancy is SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (defaults: 4). The next command can be accepted no earlier than the first IDLE cycle, so ncs is high for at least 1 cycle between transactions.
- nrd and nwr are never low at the same time. A strobe is never low while ncs=1.
- START:
  - start_out=1 for START_CYC cycles with ncs=1, then the state returns to IDLE.
  - status_ec and status_err clear on the cycle start_out first rises.
- Status: status_ec |= ec_in and status_err |= err_in on every cycle outside that clear cycle; on that clear cycle the clear has priority. The flags are cleared only by a start or by reset.
- cmd_* and start_req are ignored outside IDLE; requesters hold them until accepted.
- Phase timing: a single 8-bit down-counter loads (param−1) on entry to each timed state. The state advances when the counter is 0.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). The in-flight transaction is dropped with no rsp_valid.

Decomposition:
- Package updown_bus_pkg holds:
  - the register address constants ADDR_PLR=2'b00, ADDR_ULR=2'b01, ADDR_LLR=2'b10, ADDR_CCR=2'b11;
  - the one-hot state localparams;
  - the default timing constants.
- Sub-module bus_phase_timer: an 8-bit loadable down-counter with ports load, load_val and expired.

Test Plan:
- Defaults; write PLR=8'h10 → A0=0/A1=0, ncs low for 4 cycles, nwr low in cycles 2–3 only, bus_oe=1 with bus_dout=8'h10 throughout, no rsp_valid.
- Read ULR with the peripheral model driving 8'hFF during the strobe → A0=0/A1=1, nrd low for 2 cycles, bus_oe=0, rsp_valid pulses once with rsp_rdata=8'hFF.
- cmd_valid held for back-to-back writes (LLR=8'h05, then CCR=8'h03) → two separate 4-cycle ncs windows with ncs=1 for ≥1 cycle between them, and the correct A0/A1 (1/0, then 1/1) in each.
- cmd_valid and start_req asserted in the same IDLE cycle → the write completes first, then start_out=1 for 1 cycle with ncs=1.
- ec_in pulsed for 1 cycle → status_ec stays 1; the next start_req clears it on the start_out rising cycle.
- reset_in driven low during STROBE of a write → ncs, nwr and bus_oe return to their inactive values (ncs=1, nwr=1, bus_oe=0) without waiting for a clock edge; after release, cmd_ready=1 and no rsp_valid appears.
